pc_stack_reg: RTL

Parametrised program counter with an integrated return-address stack, the next-generation PC for the basic computer datapath. It supports increment, direct load, subroutine call (push return address and jump) and return (pop and jump). Every operation completes in a single cycle. Illegal command combinations, stack overflow and stack underflow are detected and reported through sticky flags instead of corrupting the PC.

---
 rtl/pc_stack_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_stack_reg.sv
// pc_stack_reg: program counter with an integrated return-address stack.
// Supports increment, load, call (push PC+1, jump) and return (pop, jump), one
// cycle each. Illegal command mixes, overflow and underflow raise sticky flags
// and leave the PC and stack unchanged.
module pc_stack_reg #(
    parameter int              WIDTH     = 12,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             LW        = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             INR,
    input  logic             LD,
    input  logic             CALL,
    input  logic             RET,
    input  logic [WIDTH-1:0] D,
    input  logic             CLRERR,
    output logic [WIDTH-1:0] Q,
    output logic [LW-1:0]    LVL,
    output logic             EMPTY,
    output logic             FULL,
    output logic             CARRY,
    output logic             OVF,
    output logic             UNF,
    output logic             CFL
);

    // Stack index width; storage is rounded up to a power of two so the
    // index never needs a width cast. Slots at or above LVL are never read.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SZ = 1 << IW;

    logic [WIDTH-1:0] q_q, q_d, q_inc;
    logic [LW-1:0]    lvl_q, lvl_d, lvl_m1;
    logic             empty_q, empty_d, full_q, full_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, cfl_q, cfl_d;
    logic             ovf_set, unf_set;
    logic [WIDTH-1:0] stack_q [SZ];
    logic [2:0]       n_cmd;
    logic             conflict, push;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign q_inc    = q_q + WIDTH'(1);
    assign lvl_m1   = lvl_q - LW'(1);
    assign wr_idx   = lvl_q[IW-1:0];
    assign rd_idx   = lvl_m1[IW-1:0];
    assign n_cmd    = 3'(INR) + 3'(LD) + 3'(CALL) + 3'(RET);
    assign conflict = (n_cmd > 3'd1);
    assign push     = CALL && !conflict && !full_q;

    // Next-state decode: exactly one command acts, otherwise hold
    always_comb begin
        q_d     = q_q;
        lvl_d   = lvl_q;
        carry_d = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!conflict) begin
            if (INR) begin
                q_d     = q_inc;
                carry_d = &q_q;
            end else if (LD) begin
                q_d = D;
            end else if (CALL) begin
                if (full_q) begin
                    ovf_set = 1'b1;
                end else begin
                    q_d   = D;
                    lvl_d = lvl_q + LW'(1);
                end
            end else if (RET) begin
                if (empty_q) begin
                    unf_set = 1'b1;
                end else begin
                    q_d   = stack_q[rd_idx];
                    lvl_d = lvl_m1;
                end
            end
        end
        // A new error in the same cycle as CLRERR wins
        ovf_d   = (ovf_q && !CLRERR) || ovf_set;
        unf_d   = (unf_q && !CLRERR) || unf_set;
        cfl_d   = (cfl_q && !CLRERR) || conflict;
        // Registered decodes keep EMPTY/FULL glitch-free
        empty_d = (lvl_d == '0);
        full_d  = (lvl_d == LW'(DEPTH));
    end

    // PC, level and flag registers with asynchronous clear
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q_q     <= RESET_VAL;
            lvl_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cfl_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            lvl_q   <= lvl_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cfl_q   <= cfl_d;
        end
    end

    // Return-address storage; contents survive CLR since LVL gates all reads
    always_ff @(posedge CLK) begin
        if (push) begin
            stack_q[wr_idx] <= q_inc;
        end
    end

    assign Q     = q_q;
    assign LVL   = lvl_q;
    assign EMPTY = empty_q;
    assign FULL  = full_q;
    assign CARRY = carry_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;
    assign CFL   = cfl_q;

endmodule
